// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures the CPU commit stream and exposes it to the PDU kernel through a register window.
// Optional PC-range filter (registers 8/9) is compiled in with `define COMMIT_TRACE_FILTER_EN.
module commit_trace_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] interface_addr,
  output logic [31:0] interface_rdata,
  input  logic [31:0] interface_wdata,
  input  logic        interface_we,
  input  logic        commit_en,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_instr,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  output logic        trace_stall
);

  localparam int N = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(N);
  localparam logic [DEPTH:0] HIGH_CNT = (DEPTH+1)'(N - 1);

  localparam logic [3:0] OFF_STATUS     = 4'd0;
  localparam logic [3:0] OFF_CTRL       = 4'd1;
  localparam logic [3:0] OFF_HEAD_PC    = 4'd2;
  localparam logic [3:0] OFF_HEAD_INSTR = 4'd3;
  localparam logic [3:0] OFF_HEAD_INFO  = 4'd4;
  localparam logic [3:0] OFF_HEAD_WD    = 4'd5;
  localparam logic [3:0] OFF_POP        = 4'd6;
  localparam logic [3:0] OFF_DROP_CNT   = 4'd7;
  localparam logic [3:0] OFF_FILT_LO    = 4'd8;
  localparam logic [3:0] OFF_FILT_HI    = 4'd9;

  // Entry storage, one array per field.
  logic [31:0] mem_pc    [N];
  logic [31:0] mem_instr [N];
  logic        mem_halt  [N];
  logic        mem_reg_we[N];
  logic [4:0]  mem_reg_wa[N];
  logic [31:0] mem_reg_wd[N];

  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH:0]   count;
  logic             ctrl_enable;
  logic             ctrl_stall_on_full;
  logic             ovf;
  logic             halt_seen;
  logic [31:0]      drop_cnt;

  logic [3:0] offset;
  logic       empty;
  logic       full;
  logic       wr_ctrl;
  logic       clear;
  logic       pop;
  logic       in_range;
  logic       eligible;
  logic       accept;
  logic       drop;
  logic       halt_set;

  assign offset = interface_addr[5:2];
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

  // Commit handshake: the commit stream is valid-only (commit_en); there is no per-beat
  // ready. Backpressure is trace_stall, raised one slot early so the commit already in
  // flight when the CPU sees the stall still fits.
  assign trace_stall = ctrl_enable & ctrl_stall_on_full & (count >= HIGH_CNT);

  assign wr_ctrl = interface_we & (offset == OFF_CTRL);
  assign clear   = wr_ctrl & interface_wdata[2];
  assign pop     = interface_we & (offset == OFF_POP) & ~empty;

`ifdef COMMIT_TRACE_FILTER_EN
  logic [31:0] filt_lo;
  logic [31:0] filt_hi;

  assign in_range = (commit_pc >= filt_lo) && (commit_pc <= filt_hi);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      filt_lo <= 32'h0000_0000;
      filt_hi <= 32'hFFFF_FFFF;
    end else if (interface_we) begin
      if (offset == OFF_FILT_LO) filt_lo <= interface_wdata;
      if (offset == OFF_FILT_HI) filt_hi <= interface_wdata;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  // Clear overrides push: a commit in the clearing cycle is neither stored nor counted.
  assign eligible = commit_en & ctrl_enable & in_range & ~clear;
  assign accept   = eligible & (~full | pop);
  assign drop     = eligible & full & ~pop;
  assign halt_set = eligible & commit_halt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && accept) begin
      mem_pc[wr_ptr]     <= commit_pc;
      mem_instr[wr_ptr]  <= commit_instr;
      mem_halt[wr_ptr]   <= commit_halt;
      mem_reg_we[wr_ptr] <= commit_reg_we;
      mem_reg_wa[wr_ptr] <= commit_reg_wa;
      mem_reg_wd[wr_ptr] <= commit_reg_wd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      ctrl_enable        <= 1'b0;
      ctrl_stall_on_full <= 1'b0;
      ovf                <= 1'b0;
      halt_seen          <= 1'b0;
      drop_cnt           <= '0;
    end else if (clear) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      ctrl_enable        <= interface_wdata[0];
      ctrl_stall_on_full <= interface_wdata[1];
      ovf                <= 1'b0;
      halt_seen          <= 1'b0;
      drop_cnt           <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable        <= interface_wdata[0];
        ctrl_stall_on_full <= interface_wdata[1];
      end
      if (accept) wr_ptr <= wr_ptr + DEPTH'(1);
      if (pop)    rd_ptr <= rd_ptr + DEPTH'(1);
      case ({accept, pop})
        2'b10:   count <= count + (DEPTH+1)'(1);
        2'b01:   count <= count - (DEPTH+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end
      if (halt_set) halt_seen <= 1'b1;
    end
  end

  logic [31:0] status_word;
  logic [31:0] info_word;

  always_comb begin
    status_word                = '0;
    status_word[0]             = empty;
    status_word[1]             = full;
    status_word[2]             = ovf;
    status_word[3]             = halt_seen;
    status_word[DEPTH+16:16]   = count;
    info_word                  = '0;
    info_word[0]               = mem_halt[rd_ptr];
    info_word[1]               = mem_reg_we[rd_ptr];
    info_word[12:8]            = mem_reg_wa[rd_ptr];
  end

  // Head registers read zero when empty so stale entries never leak out.
  always_comb begin
    interface_rdata = '0;
    case (offset)
      OFF_STATUS:     interface_rdata = status_word;
      OFF_CTRL:       interface_rdata = {30'd0, ctrl_stall_on_full, ctrl_enable};
      OFF_HEAD_PC:    interface_rdata = empty ? '0 : mem_pc[rd_ptr];
      OFF_HEAD_INSTR: interface_rdata = empty ? '0 : mem_instr[rd_ptr];
      OFF_HEAD_INFO:  interface_rdata = empty ? '0 : info_word;
      OFF_HEAD_WD:    interface_rdata = empty ? '0 : mem_reg_wd[rd_ptr];
      OFF_DROP_CNT:   interface_rdata = drop_cnt;
`ifdef COMMIT_TRACE_FILTER_EN
      OFF_FILT_LO:    interface_rdata = filt_lo;
      OFF_FILT_HI:    interface_rdata = filt_hi;
`endif
      default:        interface_rdata = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, interface_addr[31:6], interface_addr[1:0], interface_wdata[31:3]};

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=4).
module tb_commit_trace_buffer;

  logic        sys_clk;
  logic        sys_rst;
  logic [31:0] interface_addr;
  logic [31:0] interface_rdata;
  logic [31:0] interface_wdata;
  logic        interface_we;
  logic        commit_en;
  logic [31:0] commit_pc;
  logic [31:0] commit_instr;
  logic        commit_halt;
  logic        commit_reg_we;
  logic [4:0]  commit_reg_wa;
  logic [31:0] commit_reg_wd;
  logic        trace_stall;

  int checks = 0;
  int errors = 0;

  commit_trace_buffer #(.DEPTH(4)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .interface_addr(interface_addr),
    .interface_rdata(interface_rdata),
    .interface_wdata(interface_wdata),
    .interface_we(interface_we),
    .commit_en(commit_en),
    .commit_pc(commit_pc),
    .commit_instr(commit_instr),
    .commit_halt(commit_halt),
    .commit_reg_we(commit_reg_we),
    .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd),
    .trace_stall(trace_stall)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Driver tasks: inputs change 1ns after a rising edge, reads settle 1ns later.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    interface_addr = {26'd0, off, 2'b00};
    interface_we   = 1'b0;
    #1;
    data = interface_rdata;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    interface_addr  = {26'd0, off, 2'b00};
    interface_wdata = data;
    interface_we    = 1'b1;
    tick();
    interface_we    = 1'b0;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic halt, input logic rwe,
                            input logic [4:0] wa, input logic [31:0] wd);
    commit_en     = 1'b1;
    commit_pc     = pc;
    commit_instr  = pc ^ 32'h0000_0013;
    commit_halt   = halt;
    commit_reg_we = rwe;
    commit_reg_wa = wa;
    commit_reg_wd = wd;
  endtask

  task automatic drop_commit();
    commit_en     = 1'b0;
    commit_halt   = 1'b0;
    commit_reg_we = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc);
    set_commit(pc, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    drop_commit();
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
    bus_read(4'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h expected %h", d, 32'h0); end
    bus_read(4'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_head_pc: got %h expected %h", d, 32'h0); end
    checks++;
    if (trace_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", trace_stall); end
`ifdef COMMIT_TRACE_FILTER_EN
    bus_read(4'd9, d); checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_filt_hi: got %h expected %h", d, 32'hFFFF_FFFF); end
`endif
  endtask

  task automatic test_pop_empty();
    logic [31:0] d;
    bus_write(4'd6, 32'h1);
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL pop_empty_status: got %h expected %h", d, 32'h1); end
    do_commit(32'h1C00_0000);
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL disabled_commit_status: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [31:0] exp_pc;
    bus_write(4'd1, 32'h1);
    for (int i = 0; i < 3; i++) do_commit(32'h1C00_0000 + 32'(4 * i));
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0003_0000) begin errors++; $display("FAIL basic_status: got %h expected %h", d, 32'h0003_0000); end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h1C00_0000 + 32'(4 * i);
      bus_read(4'd2, d); checks++;
      if (d !== exp_pc) begin errors++; $display("FAIL basic_head_pc%0d: got %h expected %h", i, d, exp_pc); end
      bus_write(4'd6, 32'h0);
    end
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL basic_empty: got %h expected %h", d, 32'h1); end
    bus_read(4'd6, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL pop_reads_zero: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) do_commit(32'h2000_0000 + 32'(4 * i));
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0010_0006) begin errors++; $display("FAIL ovf_status: got %h expected %h", d, 32'h0010_0006); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL ovf_drop_cnt: got %h expected %h", d, 32'h1); end
    bus_read(4'd2, d); checks++;
    if (d !== 32'h2000_0000) begin errors++; $display("FAIL ovf_head_pc: got %h expected %h", d, 32'h2000_0000); end
    checks++;
    if (trace_stall !== 1'b0) begin errors++; $display("FAIL ovf_no_stall: got %b expected 0", trace_stall); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    bus_write(4'd1, 32'h7);
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL clear_status: got %h expected %h", d, 32'h1); end
    for (int i = 0; i < 14; i++) do_commit(32'h2400_0000 + 32'(4 * i));
    checks++;
    if (trace_stall !== 1'b0) begin errors++; $display("FAIL stall_at_14: got %b expected 0", trace_stall); end
    do_commit(32'h2400_0038);
    checks++;
    if (trace_stall !== 1'b1) begin errors++; $display("FAIL stall_at_15: got %b expected 1", trace_stall); end
    do_commit(32'h2400_003C);
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0010_0002) begin errors++; $display("FAIL stall_full_status: got %h expected %h", d, 32'h0010_0002); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL stall_drop_cnt: got %h expected %h", d, 32'h0); end
    bus_write(4'd6, 32'h0);
    bus_read(4'd0, d); checks++;
    if (d !== 32'h000F_0000) begin errors++; $display("FAIL stall_pop1_status: got %h expected %h", d, 32'h000F_0000); end
    checks++;
    if (trace_stall !== 1'b1) begin errors++; $display("FAIL stall_pop1: got %b expected 1", trace_stall); end
    bus_write(4'd6, 32'h0);
    checks++;
    if (trace_stall !== 1'b0) begin errors++; $display("FAIL stall_pop2: got %b expected 0", trace_stall); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(4'd1, 32'h5);
    for (int i = 0; i < 16; i++) do_commit(32'h3000_0000 + 32'(4 * i));
    set_commit(32'h3000_1000, 1'b0, 1'b0, 5'd0, 32'd0);
    bus_write(4'd6, 32'h0);
    drop_commit();
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0010_0002) begin errors++; $display("FAIL b2b_status: got %h expected %h", d, 32'h0010_0002); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL b2b_drop_cnt: got %h expected %h", d, 32'h0); end
    bus_read(4'd2, d); checks++;
    if (d !== 32'h3000_0004) begin errors++; $display("FAIL b2b_head: got %h expected %h", d, 32'h3000_0004); end
    for (int i = 0; i < 15; i++) bus_write(4'd6, 32'h0);
    bus_read(4'd2, d); checks++;
    if (d !== 32'h3000_1000) begin errors++; $display("FAIL b2b_tail: got %h expected %h", d, 32'h3000_1000); end
  endtask

  task automatic test_halt_info();
    logic [31:0] d;
    bus_write(4'd1, 32'h5);
    set_commit(32'h1C00_0040, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drop_commit();
    bus_read(4'd4, d); checks++;
    if (d !== 32'h0000_0503) begin errors++; $display("FAIL head_info: got %h expected %h", d, 32'h0000_0503); end
    bus_read(4'd5, d); checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL head_wd: got %h expected %h", d, 32'hDEAD_BEEF); end
    bus_read(4'd3, d); checks++;
    if (d !== 32'h1C00_0053) begin errors++; $display("FAIL head_instr: got %h expected %h", d, 32'h1C00_0053); end
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0001_0008) begin errors++; $display("FAIL halt_status: got %h expected %h", d, 32'h0001_0008); end
    // Clear racing a halt commit with the FIFO enabled.
    set_commit(32'h1C00_0044, 1'b1, 1'b0, 5'd0, 32'd0);
    bus_write(4'd1, 32'h4);
    drop_commit();
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL clear_push_status: got %h expected %h", d, 32'h1); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clear_push_drop: got %h expected %h", d, 32'h0); end
    bus_read(4'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL clear_ctrl: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_write(4'd8, 32'h1234_5678);
    bus_read(4'd12, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_12: got %h expected %h", d, 32'h0); end
`ifdef COMMIT_TRACE_FILTER_EN
    bus_read(4'd8, d); checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL filt_lo_rw: got %h expected %h", d, 32'h1234_5678); end
`else
    bus_read(4'd8, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_8: got %h expected %h", d, 32'h0); end
`endif
  endtask

`ifdef COMMIT_TRACE_FILTER_EN
  task automatic test_filter();
    logic [31:0] d;
    bus_write(4'd1, 32'h5);
    bus_write(4'd8, 32'h1C00_0100);
    bus_write(4'd9, 32'h1C00_01FF);
    do_commit(32'h1C00_00FC);
    do_commit(32'h1C00_0100);
    set_commit(32'h1C00_0200, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    drop_commit();
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0001_0000) begin errors++; $display("FAIL filt_status: got %h expected %h", d, 32'h0001_0000); end
    bus_read(4'd2, d); checks++;
    if (d !== 32'h1C00_0100) begin errors++; $display("FAIL filt_head_pc: got %h expected %h", d, 32'h1C00_0100); end
    bus_read(4'd7, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL filt_drop_cnt: got %h expected %h", d, 32'h0); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(4'd1, 32'h3);
    for (int i = 0; i < 5; i++) do_commit(32'h4000_0000 + 32'(4 * i));
    set_commit(32'h4000_0100, 1'b1, 1'b0, 5'd0, 32'd0);
    interface_addr  = 32'h18;
    interface_wdata = 32'h0;
    interface_we    = 1'b1;
    sys_rst         = 1'b1;
    tick();
    interface_we    = 1'b0;
    sys_rst         = 1'b0;
    drop_commit();
    bus_read(4'd0, d); checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL reset_mid_status: got %h expected %h", d, 32'h1); end
    bus_read(4'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_ctrl: got %h expected %h", d, 32'h0); end
  endtask

  initial begin
    sys_rst         = 1'b1;
    interface_addr  = '0;
    interface_wdata = '0;
    interface_we    = 1'b0;
    commit_en       = 1'b0;
    commit_pc       = '0;
    commit_instr    = '0;
    commit_halt     = 1'b0;
    commit_reg_we   = 1'b0;
    commit_reg_wa   = '0;
    commit_reg_wd   = '0;
    test_reset();
    test_pop_empty();
    test_basic();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_halt_info();
    test_unmapped();
`ifdef COMMIT_TRACE_FILTER_EN
    test_filter();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
